// File: rtl/seq_chunk_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice per clock, reused across the word.
// Valid/ready on both sides; signed-overflow, carry and zero flags registered with the result.
module seq_chunk_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // state  | meaning
  // IDLE   | waiting for an operation, in_ready=1
  // RUN    | one slice added per edge, r_idx selects the slice
  // DONE   | result held with out_valid=1 until out_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 2) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0 || (WIDTH / CHUNK) < 2) begin : g_param_err
    $error("seq_chunk_addsub: WIDTH must be a multiple of CHUNK with at least two chunks");
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_out_valid;

  int               w_base;
  logic [CHUNK-1:0] w_slice_a;
  logic [CHUNK-1:0] w_slice_b;
  logic [CHUNK:0]   w_slice_res;
  logic             w_msb_cin;
  logic [WIDTH-1:0] w_sum_next;

  assign w_base = int'(r_idx) * CHUNK;

  always_comb begin
    w_slice_a   = r_a[w_base +: CHUNK];
    w_slice_b   = r_b[w_base +: CHUNK];
    w_slice_res = {1'b0, w_slice_a} + {1'b0, w_slice_b} + {{CHUNK{1'b0}}, r_carry};
    w_sum_next  = r_sum;
    w_sum_next[w_base +: CHUNK] = w_slice_res[CHUNK-1:0];
  end

  // Carry into the word MSB recovered from that bit's operands and sum bit.
  assign w_msb_cin = w_slice_a[CHUNK-1] ^ w_slice_b[CHUNK-1] ^ w_slice_res[CHUNK-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_slice_res[CHUNK];
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_cout      <= w_slice_res[CHUNK];
            r_ovf       <= w_msb_cin ^ w_slice_res[CHUNK];
            r_zero      <= (w_sum_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_seq_chunk_addsub.sv
// Bench for seq_chunk_addsub: directed vector table at 32/4, hand sequences for
// backpressure and abort-by-reset, and a reference-model regression at 32/4 and 16/8.
module tb_seq_chunk_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        in_valid0, in_ready0, cin0, sub0, out_valid0, out_ready0, cout0, ovf0, zero0;
  logic [31:0] a0, b0, sum0;
  logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1, zero1;
  logic [15:0] a1, b1, sum1;

  seq_chunk_addsub #(.WIDTH(32), .CHUNK(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
    .cin(cin0), .sub(sub0), .out_valid(out_valid0), .out_ready(out_ready0), .sum(sum0),
    .cout(cout0), .ovf(ovf0), .zero(zero0));

  seq_chunk_addsub #(.WIDTH(16), .CHUNK(8)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
    .cout(cout1), .ovf(ovf1), .zero(zero1));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, output logic [31:0] s,
                           output logic co, output logic ov, output logic z);
    logic [31:0] mask, aa, bb;
    logic [32:0] full;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    aa   = a & mask;
    bb   = (sub ? ~b : b) & mask;
    full = {1'b0, aa} + {1'b0, bb} + {32'b0, (sub ? 1'b1 : cin)};
    s    = full[31:0] & mask;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    z    = (s == 32'h0);
  endtask

  task automatic run0(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic sub, output logic [31:0] s, output logic co,
                      output logic ov, output logic z, output int lat);
    @(negedge clk);
    a0 = a; b0 = b; cin0 = cin; sub0 = sub; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    a0 = ~a; b0 = $urandom; cin0 = ~cin; sub0 = ~sub;
    lat = 0;
    while (!out_valid0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sum0; co = cout0; ov = ovf0; z = zero0;
    @(negedge clk); out_ready0 = 1'b1;
    @(posedge clk); #1; out_ready0 = 1'b0;
  endtask

  task automatic run1(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, output logic [15:0] s, output logic co,
                      output logic ov, output logic z, output int lat);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = cin; sub1 = sub; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    a1 = ~a; b1 = 16'($urandom); cin1 = ~cin; sub1 = ~sub;
    lat = 0;
    while (!out_valid1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sum1; co = cout1; ov = ovf1; z = zero1;
    @(negedge clk); out_ready1 = 1'b1;
    @(posedge clk); #1; out_ready1 = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] s, es;
    logic [15:0] s16;
    logic        co, ov, z, eco, eov, ez;
    int          lat, seen;

    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h7FFF_FFFE, 32'h0000_0000, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid0 = 1'b0; out_ready0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    #1;
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_sum", sum0, 0);
    chk("rst_flags", {cout0, ovf0, zero0}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run0(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, co, ov, z, lat);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_sum", i), s, vecs[i].s);
      chk($sformatf("vec%0d_cout", i), co, vecs[i].co);
      chk($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
      chk($sformatf("vec%0d_zero", i), z, vecs[i].z);
      chk($sformatf("vec%0d_idle_after", i), {in_ready0, out_valid0}, 2'b10);
    end

    // Backpressure with in_valid hammered during RUN and DONE.
    @(negedge clk);
    a0 = 32'h10; b0 = 32'h20; cin0 = 1'b0; sub0 = 1'b0; in_valid0 = 1'b1;
    @(posedge clk); #1;
    a0 = 32'hDEAD_BEEF; b0 = 32'h1111_1111; sub0 = 1'b1;
    chk("bp_in_ready_run", in_ready0, 0);
    lat = 0;
    while (!out_valid0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", lat, 8);
    a0 = 32'h0BAD_F00D;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", k), out_valid0, 1);
      chk($sformatf("bp_hold%0d_sum", k), sum0, 32'h30);
      chk($sformatf("bp_hold%0d_in_ready", k), in_ready0, 0);
    end
    in_valid0 = 1'b0;
    @(negedge clk); out_ready0 = 1'b1;
    @(posedge clk); #1; out_ready0 = 1'b0;
    chk("bp_release_valid", out_valid0, 0);
    chk("bp_release_in_ready", in_ready0, 1);
    chk("bp_release_sum_kept", sum0, 32'h30);
    run0(32'h100, 32'h1, 1'b0, 1'b0, s, co, ov, z, lat);
    chk("bp_next_sum", s, 32'h101);
    chk("bp_next_latency", lat, 8);

    // Reset three edges into an operation aborts it.
    @(negedge clk);
    a0 = 32'h55; b0 = 32'h66; cin0 = 1'b0; sub0 = 1'b0; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_sum", sum0, 0);
    chk("abort_out_valid", out_valid0, 0);
    chk("abort_in_ready", in_ready0, 1);
    chk("abort_flags", {cout0, ovf0, zero0}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid0) seen++;
    end
    chk("abort_no_valid", seen, 0);
    run0(32'h1, 32'h2, 1'b0, 1'b0, s, co, ov, z, lat);
    chk("after_abort_sum", s, 32'h3);
    chk("after_abort_latency", lat, 8);

    // 16/8 configuration.
    run1(16'h00FF, 16'h0001, 1'b0, 1'b0, s16, co, ov, z, lat);
    chk("w16_latency", lat, 2);
    chk("w16_sum", s16, 16'h0100);
    chk("w16_cout", co, 0);
    chk("w16_ovf", ov, 0);
    run1(16'h7FFF, 16'h0001, 1'b0, 1'b0, s16, co, ov, z, lat);
    chk("w16_ovf_sum", s16, 16'h8000);
    chk("w16_ovf_flag", ov, 1);

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      logic rc, rs;
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      if (i % 10 == 0) rb = ra;
      if (i % 10 == 1) ra = 32'h8000_0000;
      run0(ra, rb, rc, rs, s, co, ov, z, lat);
      ref_model(32, ra, rb, rc, rs, es, eco, eov, ez);
      chk("rnd32_latency", lat, 8);
      chk("rnd32_sum", s, es);
      chk("rnd32_flags", {co, ov, z}, {eco, eov, ez});
    end

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      logic rc, rs;
      ra = {16'h0, 16'($urandom)}; rb = {16'h0, 16'($urandom)};
      rc = 1'($urandom); rs = 1'($urandom);
      if (i % 10 == 0) rb = ra;
      run1(ra[15:0], rb[15:0], rc, rs, s16, co, ov, z, lat);
      ref_model(16, ra, rb, rc, rs, es, eco, eov, ez);
      chk("rnd16_latency", lat, 2);
      chk("rnd16_sum", s16, es[15:0]);
      chk("rnd16_flags", {co, ov, z}, {eco, eov, ez});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
